// File: rtl/mmio_pkg.sv
// Shared types and defaults for the MMIO port controller.
// The optional wait timeout is enabled with the MMIO_TIMEOUT_EN macro.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned STATUS_OFS  = 0;
    localparam int unsigned DATA_OFS    = 1;
    localparam int unsigned DEF_DW      = 16;
    localparam int unsigned DEF_AW      = 16;
    localparam int unsigned DEF_NUM_DEV = 4;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam logic [15:0] DEF_IO_BASE = 16'hFE00;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational MAR decode into memory, device slot/register, or unmapped.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned NUM_DEV = DEF_NUM_DEV,
    parameter logic [AW-1:0] IO_BASE = AW'(DEF_IO_BASE)
) (
    input  logic [AW-1:0] i_mar,
    output logic          o_is_mem,
    output logic          o_is_dev,
    output logic [3:0]    o_dev_idx,
    output logic          o_dev_reg,
    output logic          o_unmapped
);

    localparam int unsigned EW = AW + 1;

    // One extra bit so the end of the I/O window cannot wrap.
    logic [EW-1:0] w_mar_x;
    logic [EW-1:0] w_base_x;
    logic [EW-1:0] w_end_x;
    logic [AW-1:0] w_off;

    assign w_mar_x  = EW'(i_mar);
    assign w_base_x = EW'(IO_BASE);
    assign w_end_x  = w_base_x + EW'(2 * NUM_DEV);
    assign w_off    = i_mar - IO_BASE;

    assign o_is_mem   = (w_mar_x < w_base_x);
    assign o_is_dev   = !o_is_mem && (w_mar_x < w_end_x);
    assign o_unmapped = !o_is_mem && !o_is_dev;
    assign o_dev_idx  = 4'(w_off >> 1);
    assign o_dev_reg  = (w_off[0] == 1'(DATA_OFS));

endmodule

// File: rtl/mmio_port_ctl.sv
// MAR/MDR bus port that steers accesses to memory or I/O device slots.
// Define MMIO_TIMEOUT_EN to abort unacknowledged accesses after TIMEOUT cycles.
module mmio_port_ctl
    import mmio_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned NUM_DEV = DEF_NUM_DEV,
    parameter logic [AW-1:0] IO_BASE = AW'(DEF_IO_BASE),
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         bus_in,
    output logic [DW-1:0]         bus_out,
    output logic                  bus_oe,
    input  logic                  ld_mar,
    input  logic                  ld_mdr,
    input  logic                  gate_mdr,
    input  logic                  mio_en,
    input  logic                  r_w,
    output logic                  ready,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    input  logic                  mem_ack,
    output logic [NUM_DEV-1:0]    dev_req,
    output logic                  dev_we,
    output logic                  dev_reg,
    output logic [DW-1:0]         dev_wdata,
    input  logic [NUM_DEV*DW-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]    dev_ack,
    output logic [NUM_DEV-1:0]    dev_rd_done
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW-1:0]        r_mar;
    logic [AW-1:0]        w_mar_nxt;
    logic [DW-1:0]        r_mdr;
    logic [DW-1:0]        w_mdr_nxt;
    logic                 r_we;
    logic                 w_we_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 r_ready;
    logic                 r_mem_req;
    logic [NUM_DEV-1:0]   r_dev_req;
    logic [NUM_DEV-1:0]   r_rd_done;
    logic [NUM_DEV-1:0]   w_rd_done_nxt;

    logic                 w_is_mem;
    logic                 w_is_dev;
    logic [3:0]           w_dev_idx;
    logic                 w_dev_reg;
    logic                 w_unmapped;
    logic [NUM_DEV-1:0]   w_dev_sel;
    logic [DW-1:0]        w_dev_rdata;
    logic [DW-1:0]        w_rdata;
    logic                 w_ack;
    logic                 w_timeout;

    mmio_addr_decode #(
        .AW      (AW),
        .NUM_DEV (NUM_DEV),
        .IO_BASE (IO_BASE)
    ) u_decode (
        .i_mar      (r_mar),
        .o_is_mem   (w_is_mem),
        .o_is_dev   (w_is_dev),
        .o_dev_idx  (w_dev_idx),
        .o_dev_reg  (w_dev_reg),
        .o_unmapped (w_unmapped)
    );

    // Target selection; MAR is frozen outside IDLE so this is stable in WAIT.
    assign w_dev_sel = NUM_DEV'(1) << w_dev_idx;

    always_comb begin
        w_dev_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (w_dev_sel[i]) begin
                w_dev_rdata = w_dev_rdata | dev_rdata[i*DW +: DW];
            end
        end
    end

    assign w_ack   = w_is_mem ? mem_ack : (|(dev_ack & w_dev_sel));
    assign w_rdata = w_is_mem ? mem_rdata : w_dev_rdata;

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Counts consecutive WAIT cycles; cleared whenever the FSM leaves WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT && w_state_nxt == ST_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_mar_nxt     = r_mar;
        w_mdr_nxt     = r_mdr;
        w_we_nxt      = r_we;
        w_err_nxt     = r_err;
        w_rd_done_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (ld_mar) begin
                    w_mar_nxt = AW'(bus_in);
                end
                if (!mio_en) begin
                    if (ld_mdr) begin
                        w_mdr_nxt = bus_in;
                    end
                end else begin
                    w_we_nxt = r_w;
                    if (w_unmapped) begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = 1'b1;
                        if (!r_w) begin
                            w_mdr_nxt = '0;
                        end
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_err_nxt   = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (w_ack) begin
                    if (mio_en) begin
                        w_state_nxt = ST_DONE;
                        if (!r_we) begin
                            w_mdr_nxt = w_rdata;
                            if (w_is_dev && w_dev_reg) begin
                                w_rd_done_nxt = w_dev_sel;
                            end
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                    if (!r_we) begin
                        w_mdr_nxt = '1;
                    end
                end
            end
            ST_DONE: begin
                if (!mio_en) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and Moore outputs registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mar     <= '0;
            r_mdr     <= '0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_ready   <= 1'b0;
            r_mem_req <= 1'b0;
            r_dev_req <= '0;
            r_rd_done <= '0;
        end else begin
            r_mar     <= w_mar_nxt;
            r_mdr     <= w_mdr_nxt;
            r_we      <= w_we_nxt;
            r_err     <= w_err_nxt;
            r_ready   <= (w_state_nxt == ST_DONE);
            r_mem_req <= (w_state_nxt == ST_WAIT) && w_is_mem;
            r_dev_req <= ((w_state_nxt == ST_WAIT) && w_is_dev) ? w_dev_sel : '0;
            r_rd_done <= w_rd_done_nxt;
        end
    end

    assign bus_out     = r_mdr;
    assign bus_oe      = gate_mdr;
    assign ready       = r_ready;
    assign err         = r_err;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_mar;
    assign mem_wdata   = r_mdr;
    assign dev_req     = r_dev_req;
    assign dev_we      = r_we;
    assign dev_reg     = w_dev_reg;
    assign dev_wdata   = r_mdr;
    assign dev_rd_done = r_rd_done;

endmodule

// File: tb/tb_mmio_port_ctl.sv
// Scoreboard bench for mmio_port_ctl: expected MDR values queued at access start.
module tb_mmio_port_ctl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned ND = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  bus_in;
    logic [DW-1:0]  bus_out;
    logic           bus_oe;
    logic           ld_mar, ld_mdr, gate_mdr, mio_en, r_w;
    logic           ready, err;
    logic           mem_req, mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata, mem_rdata;
    logic           mem_ack;
    logic [ND-1:0]  dev_req;
    logic           dev_we, dev_reg;
    logic [DW-1:0]  dev_wdata;
    logic [ND*DW-1:0] dev_rdata;
    logic [ND-1:0]  dev_ack;
    logic [ND-1:0]  dev_rd_done;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] q_exp[$];
    logic [DW-1:0] exp_v;

    mmio_port_ctl #(
        .DW(DW), .AW(AW), .NUM_DEV(ND), .IO_BASE(16'hFE00), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .gate_mdr(gate_mdr), .mio_en(mio_en), .r_w(r_w),
        .ready(ready), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dev_req(dev_req), .dev_we(dev_we), .dev_reg(dev_reg), .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata), .dev_ack(dev_ack), .dev_rd_done(dev_rd_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [15:0] a);
        bus_in = a; ld_mar = 1'b1; tick(); ld_mar = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] d);
        bus_in = d; ld_mdr = 1'b1; tick(); ld_mdr = 1'b0;
    endtask

    function automatic logic [DW-1:0] pop_exp();
        if (q_exp.size() == 0) return 'x;
        return q_exp.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        n_vec++;
        if ({ready, err, mem_req, dev_req, dev_rd_done} !== 11'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b expected 0", {ready, err, mem_req, dev_req, dev_rd_done});
        end
        n_vec++;
        if (bus_out !== 16'h0 || mem_addr !== 16'h0) begin
            n_err++; $display("FAIL reset_regs: got mdr=%h mar=%h expected 0/0", bus_out, mem_addr);
        end
    endtask

    task automatic test_mem_read();
        load_mar(16'h3000);
        r_w = 1'b0; mio_en = 1'b1; q_exp.push_back(16'hBEEF); tick();
        n_vec++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h3000 || dev_req !== 4'b0) begin
            n_err++; $display("FAIL memrd_req: got req=%b we=%b addr=%h dev=%b expected 1/0/3000/0", mem_req, mem_we, mem_addr, dev_req);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (mem_req !== 1'b1 || ready !== 1'b0) begin
                n_err++; $display("FAIL memrd_hold%0d: got req=%b ready=%b expected 1/0", i, mem_req, ready);
            end
        end
        mem_rdata = 16'hBEEF; mem_ack = 1'b1; tick(); mem_ack = 1'b0; mem_rdata = 16'h0;
        exp_v = pop_exp();
        n_vec++;
        if (ready !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0 || bus_out !== exp_v) begin
            n_err++; $display("FAIL memrd_done: got ready=%b err=%b req=%b mdr=%h expected 1/0/0/%h", ready, err, mem_req, bus_out, exp_v);
        end
        tick();
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++; $display("FAIL memrd_hold_ready: got %b expected 1", ready);
        end
        mio_en = 1'b0; tick();
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL memrd_release: got %b expected 0", ready);
        end
    endtask

    task automatic test_dev_write();
        load_mdr(16'h0041);
        load_mar(16'hFE03);
        r_w = 1'b1; mio_en = 1'b1; q_exp.push_back(16'h0041); tick();
        n_vec++;
        if (dev_req !== 4'b0010 || dev_reg !== 1'b1 || dev_we !== 1'b1 || dev_wdata !== 16'h0041 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL devwr_req: got dev=%b reg=%b we=%b wd=%h mem=%b expected 0010/1/1/0041/0", dev_req, dev_reg, dev_we, dev_wdata, mem_req);
        end
        dev_ack = 4'b0001; mem_ack = 1'b1; tick(); dev_ack = 4'b0; mem_ack = 1'b0;
        n_vec++;
        if (dev_req !== 4'b0010 || ready !== 1'b0) begin
            n_err++; $display("FAIL devwr_foreign_ack: got dev=%b ready=%b expected 0010/0", dev_req, ready);
        end
        dev_ack = 4'b0010; tick(); dev_ack = 4'b0;
        exp_v = pop_exp();
        n_vec++;
        if (ready !== 1'b1 || dev_req !== 4'b0 || dev_rd_done !== 4'b0 || bus_out !== exp_v) begin
            n_err++; $display("FAIL devwr_done: got ready=%b dev=%b rd_done=%b mdr=%h expected 1/0/0/%h", ready, dev_req, dev_rd_done, bus_out, exp_v);
        end
        mio_en = 1'b0; tick();
    endtask

    task automatic test_dev_read(input logic [15:0] addr, input logic [15:0] data,
                                 input logic [ND-1:0] exp_pulse);
        load_mar(addr);
        dev_rdata = '0;
        dev_rdata[16 +: 16] = data;
        r_w = 1'b0; mio_en = 1'b1; q_exp.push_back(data); tick();
        n_vec++;
        if (dev_req !== 4'b0010 || dev_reg !== addr[0]) begin
            n_err++; $display("FAIL devrd_req %h: got dev=%b reg=%b expected 0010/%b", addr, dev_req, dev_reg, addr[0]);
        end
        dev_ack = 4'b0010; tick(); dev_ack = 4'b0;
        exp_v = pop_exp();
        n_vec++;
        if (ready !== 1'b1 || bus_out !== exp_v || dev_rd_done !== exp_pulse) begin
            n_err++; $display("FAIL devrd_done %h: got ready=%b mdr=%h rd_done=%b expected 1/%h/%b", addr, ready, bus_out, dev_rd_done, exp_v, exp_pulse);
        end
        tick();
        n_vec++;
        if (dev_rd_done !== 4'b0) begin
            n_err++; $display("FAIL devrd_pulse_len %h: got %b expected 0000", addr, dev_rd_done);
        end
        mio_en = 1'b0; tick();
    endtask

    task automatic test_unmapped();
        load_mdr(16'h1234);
        load_mar(16'hFE10);
        r_w = 1'b0; mio_en = 1'b1; q_exp.push_back(16'h0000); tick();
        exp_v = pop_exp();
        n_vec++;
        if (ready !== 1'b1 || err !== 1'b1 || bus_out !== exp_v || mem_req !== 1'b0 || dev_req !== 4'b0) begin
            n_err++; $display("FAIL unmapped: got ready=%b err=%b mdr=%h mem=%b dev=%b expected 1/1/%h/0/0", ready, err, bus_out, mem_req, dev_req, exp_v);
        end
        mio_en = 1'b0; tick();
    endtask

    task automatic test_back_to_back();
        // Immediate acks: ready two cycles after mio_en; err from prior access cleared.
        load_mdr(16'hC0DE);
        load_mar(16'h0100);
        r_w = 1'b1; mio_en = 1'b1; q_exp.push_back(16'hC0DE); tick();
        n_vec++;
        if (err !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'hC0DE) begin
            n_err++; $display("FAIL b2b_wr_req: got err=%b req=%b we=%b wd=%h expected 0/1/1/c0de", err, mem_req, mem_we, mem_wdata);
        end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        exp_v = pop_exp();
        n_vec++;
        if (ready !== 1'b1 || bus_out !== exp_v) begin
            n_err++; $display("FAIL b2b_wr_done: got ready=%b mdr=%h expected 1/%h", ready, bus_out, exp_v);
        end
        mio_en = 1'b0; tick();
        r_w = 1'b0; mio_en = 1'b1; q_exp.push_back(16'h5A5A); tick();
        mem_rdata = 16'h5A5A; mem_ack = 1'b1; tick(); mem_ack = 1'b0; mem_rdata = 16'h0;
        exp_v = pop_exp();
        n_vec++;
        if (ready !== 1'b1 || bus_out !== exp_v || err !== 1'b0) begin
            n_err++; $display("FAIL b2b_rd_done: got ready=%b mdr=%h err=%b expected 1/%h/0", ready, bus_out, err, exp_v);
        end
        mio_en = 1'b0; tick();
    endtask

    task automatic test_abort();
        load_mdr(16'h5555);
        load_mar(16'h2000);
        r_w = 1'b0; mio_en = 1'b1; tick();
        mio_en = 1'b0; mem_rdata = 16'hAAAA; mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        n_vec++;
        if (ready !== 1'b0 || mem_req !== 1'b0 || bus_out !== 16'h5555) begin
            n_err++; $display("FAIL abort: got ready=%b req=%b mdr=%h expected 0/0/5555", ready, mem_req, bus_out);
        end
        tick();
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL abort_no_ready: got %b expected 0", ready);
        end
    endtask

    task automatic test_timeout();
        load_mar(16'h4000);
        r_w = 1'b0; mio_en = 1'b1; tick();
`ifdef MMIO_TIMEOUT_EN
        q_exp.push_back(16'hFFFF);
        for (int i = 0; i < 7; i++) begin
            tick();
            n_vec++;
            if (mem_req !== 1'b1) begin
                n_err++; $display("FAIL timeout_hold%0d: got req=%b expected 1", i, mem_req);
            end
        end
        tick();
        exp_v = pop_exp();
        n_vec++;
        if (mem_req !== 1'b0 || ready !== 1'b1 || err !== 1'b1 || bus_out !== exp_v) begin
            n_err++; $display("FAIL timeout_expire: got req=%b ready=%b err=%b mdr=%h expected 0/1/1/%h", mem_req, ready, err, bus_out, exp_v);
        end
        mio_en = 1'b0; tick();
`else
        for (int i = 0; i < 99; i++) tick();
        n_vec++;
        if (mem_req !== 1'b1 || ready !== 1'b0 || err !== 1'b0) begin
            n_err++; $display("FAIL no_timeout: got req=%b ready=%b err=%b expected 1/0/0", mem_req, ready, err);
        end
        mio_en = 1'b0; mem_ack = 1'b1; tick(); mem_ack = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_wait();
        load_mdr(16'h7777);
        load_mar(16'h1000);
        r_w = 1'b0; mio_en = 1'b1; tick();
        n_vec++;
        if (mem_req !== 1'b1) begin
            n_err++; $display("FAIL rstwait_req: got %b expected 1", mem_req);
        end
        #2 rst = 1'b1; mio_en = 1'b0;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || ready !== 1'b0 || mem_addr !== 16'h0 || bus_out !== 16'h0) begin
            n_err++; $display("FAIL rstwait_async: got req=%b ready=%b mar=%h mdr=%h expected 0/0/0/0", mem_req, ready, mem_addr, bus_out);
        end
        tick(); rst = 1'b0; tick();
        load_mar(16'h0010);
        r_w = 1'b0; mio_en = 1'b1; q_exp.push_back(16'h1357); tick();
        mem_rdata = 16'h1357; mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        exp_v = pop_exp();
        n_vec++;
        if (ready !== 1'b1 || bus_out !== exp_v || err !== 1'b0) begin
            n_err++; $display("FAIL rstwait_next: got ready=%b mdr=%h err=%b expected 1/%h/0", ready, bus_out, err, exp_v);
        end
        mio_en = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b0; bus_in = '0; ld_mar = 1'b0; ld_mdr = 1'b0; gate_mdr = 1'b1;
        mio_en = 1'b0; r_w = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        dev_rdata = '0; dev_ack = '0;
        test_reset();
        test_mem_read();
        test_dev_write();
        test_dev_read(16'hFE03, 16'h0061, 4'b0010);
        test_dev_read(16'hFE02, 16'h0005, 4'b0000);
        test_unmapped();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_reset_mid_wait();
        n_vec++;
        if (q_exp.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
